// File: rtl/vga_sync_if.sv
// vga_sync_if
//   Bundles the pixel-tick input and the timing outputs of the VGA sync
//   generator so they can be passed between stages as one port.
//   Signals:
//     tick        pixel enable from the ticker (one clk wide)
//     hsync       horizontal sync, active low
//     vsync       vertical sync, active low
//     video_on    high while the current pixel is visible
//     pixel_x     current horizontal count
//     pixel_y     current vertical count
//     frame_tick  one-clk strobe on the tick that ends a frame
//   Modports:
//     master      the timing generator (consumes tick, drives timing)
//     slave       a downstream observer (pixel/colour stage)
interface vga_sync_if;
   logic       tick;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       frame_tick;

   modport master (
      input  tick,
      output hsync,
      output vsync,
      output video_on,
      output pixel_x,
      output pixel_y,
      output frame_tick
   );

   modport slave (
      input tick,
      input hsync,
      input vsync,
      input video_on,
      input pixel_x,
      input pixel_y,
      input frame_tick
   );
endinterface

// File: rtl/vga_sync.sv
// vga_sync
//   Horizontal/vertical timing generator for a VGA display path. The pixel
//   counters advance only on clk cycles where the pixel tick is high. Sync
//   and visible-region flags are registered from the next counter values so
//   they always describe the pixel_x/pixel_y presented alongside them.
//   Ports:
//     clk    system clock
//     reset  asynchronous reset, active low
//     bus    vga_sync_if master: tick in; hsync, vsync, video_on,
//            pixel_x, pixel_y, frame_tick out
module vga_sync #(
   parameter int unsigned H_DISPLAY = 32'd640,
   parameter int unsigned H_FRONT   = 32'd16,
   parameter int unsigned H_SYNC    = 32'd96,
   parameter int unsigned H_BACK    = 32'd48,
   parameter int unsigned V_DISPLAY = 32'd480,
   parameter int unsigned V_FRONT   = 32'd10,
   parameter int unsigned V_SYNC    = 32'd2,
   parameter int unsigned V_BACK    = 32'd33
) (
   input  logic        clk,
   input  logic        reset,
   vga_sync_if.master  bus
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   // Totals are at most 1024, so every boundary below fits in 10 bits.
   localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 32'd1);
   localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 32'd1);
   localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
   localparam logic [9:0] H_SYNC_LO  = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] H_SYNC_HI  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 32'd1);
   localparam logic [9:0] V_SYNC_LO  = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] V_SYNC_HI  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 32'd1);

   logic [9:0] h_count_r;
   logic [9:0] v_count_r;
   logic       hsync_r;
   logic       vsync_r;
   logic       video_on_r;

   logic [9:0] h_next_s;
   logic [9:0] v_next_s;
   logic       h_wrap_s;
   logic       v_wrap_s;

   // Inclusive range test used for the sync pulse windows.
   function automatic logic in_window(input logic [9:0] val,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
      return (val >= lo) && (val <= hi);
   endfunction

   // Next counter values: h wraps at the end of a line, v steps only on that wrap.
   always_comb begin
      h_next_s = h_count_r;
      v_next_s = v_count_r;
      h_wrap_s = (h_count_r == H_MAX);
      v_wrap_s = (v_count_r == V_MAX);
      if (h_wrap_s) begin
         h_next_s = 10'd0;
         if (v_wrap_s) begin
            v_next_s = 10'd0;
         end else begin
            v_next_s = v_count_r + 10'd1;
         end
      end else begin
         h_next_s = h_count_r + 10'd1;
         v_next_s = v_count_r;
      end
   end

   // Counter and timing-flag registers, all loaded under the pixel tick.
   // Flags are derived from the next counts so they stay aligned with them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_count_r  <= 10'd0;
         v_count_r  <= 10'd0;
         hsync_r    <= 1'b1;
         vsync_r    <= 1'b1;
         video_on_r <= 1'b0;   // blanked while in reset, including pixel (0,0)
      end else if (bus.tick) begin
         h_count_r  <= h_next_s;
         v_count_r  <= v_next_s;
         hsync_r    <= ~in_window(h_next_s, H_SYNC_LO, H_SYNC_HI);
         vsync_r    <= ~in_window(v_next_s, V_SYNC_LO, V_SYNC_HI);
         video_on_r <= (h_next_s < H_VIS) && (v_next_s < V_VIS);
      end else begin
         h_count_r  <= h_count_r;
         v_count_r  <= v_count_r;
         hsync_r    <= hsync_r;
         vsync_r    <= vsync_r;
         video_on_r <= video_on_r;
      end
   end

   assign bus.pixel_x    = h_count_r;
   assign bus.pixel_y    = v_count_r;
   assign bus.hsync      = hsync_r;
   assign bus.vsync      = vsync_r;
   assign bus.video_on   = video_on_r;
   // Combinational so the downstream stage sees it on the very tick that ends the frame.
   assign bus.frame_tick = bus.tick & h_wrap_s & v_wrap_s;

endmodule
